instr_mem_loader: RTL and testbench



---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_array.sv | 27 ++
 rtl/instr_mem_loader.sv | 127 ++++++++++++
 tb/tb_instr_mem_loader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and default widths for the loadable instruction memory
package imem_pkg;

   localparam int DEF_OPCODE_W   = 3;
   localparam int DEF_ADDR_W     = 5;
   localparam int DEF_PC_W       = 5;
   localparam int DEF_NOP_OPCODE = 0;
   localparam int DEF_WORD_W     = DEF_OPCODE_W + DEF_ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

   // Opcode sits in the LSBs, address field above it
   typedef struct packed {
      logic [DEF_ADDR_W-1:0]   address;
      logic [DEF_OPCODE_W-1:0] opcode;
   } instr_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x WORD_W program storage, one synchronous write port, one read port
module imem_array
   import imem_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int AW     = DEF_PC_W
) (
   input  logic              Clk,
   input  logic              Wr_en,
   input  logic [AW-1:0]     Wr_addr,
   input  logic [WORD_W-1:0] Wr_data,
   input  logic [AW-1:0]     Rd_addr,
   output logic [WORD_W-1:0] Rd_data
);

   logic [WORD_W-1:0] mem [2**AW];

   always_ff @(posedge Clk) begin
      if (Wr_en) begin
         mem[Wr_addr] <= Wr_data;
      end
   end

   // Read is combinational; the fetch register in the parent supplies the cycle of latency
   assign Rd_data = mem[Rd_addr];

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loadable instruction memory with registered fetch port; IMEM_PC_WRAP_EN wraps out-of-program fetches
module instr_mem_loader
   import imem_pkg::*;
#(
   parameter int OPCODE_W   = DEF_OPCODE_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int PC_W       = DEF_PC_W,
   parameter int NOP_OPCODE = DEF_NOP_OPCODE
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       Load_start,
   input  logic                       Load_valid,
   input  logic                       Load_last,
   input  logic [OPCODE_W+ADDR_W-1:0] Load_data,
   output logic                       Load_busy,
   output logic [PC_W:0]              Prog_len,
   input  logic                       Fetch_en,
   input  logic                       Stall,
   input  logic [PC_W-1:0]            Program_counter,
   output logic [OPCODE_W-1:0]        Opcode,
   output logic [ADDR_W-1:0]          Address,
   output logic                       Instr_valid,
   output logic                       Pc_oob
);

   localparam int WORD_W = OPCODE_W + ADDR_W;
   localparam int DEPTH  = 2**PC_W;

   state_t            state;
   logic [PC_W-1:0]   ptr;
   logic [PC_W-1:0]   rd_addr;
   logic [WORD_W-1:0] rd_word;
   logic              wr_en;
   logic              fetch_oob;

   // Load_start outranks a same-cycle Load_valid, so that word is dropped
   assign wr_en     = (state == LOAD) && Load_valid && !Load_start;
   assign fetch_oob = {1'b0, Program_counter} >= Prog_len;
   assign Load_busy = (state == LOAD);

`ifdef IMEM_PC_WRAP_EN
   always_comb begin
      rd_addr = Program_counter;
      if (fetch_oob && Prog_len != '0) begin
         rd_addr = PC_W'({1'b0, Program_counter} % Prog_len);
      end
   end
`else
   assign rd_addr = Program_counter;
`endif

   imem_array #(
      .WORD_W (WORD_W),
      .AW     (PC_W)
   ) u_array (
      .Clk     (Clk),
      .Wr_en   (wr_en),
      .Wr_addr (ptr),
      .Wr_data (Load_data),
      .Rd_addr (rd_addr),
      .Rd_data (rd_word)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         ptr         <= '0;
         Prog_len    <= '0;
         Opcode      <= '0;
         Address     <= '0;
         Instr_valid <= 1'b0;
         Pc_oob      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Instr_valid <= 1'b0;
               if (Load_start) begin
                  state <= LOAD;
                  ptr   <= '0;
               end
            end
            LOAD: begin
               Instr_valid <= 1'b0;
               if (Load_start) begin
                  ptr <= '0;
               end else if (Load_valid) begin
                  ptr <= ptr + PC_W'(1);
                  // Last slot closes the load even without Load_last
                  if (Load_last || ptr == PC_W'(DEPTH - 1)) begin
                     Prog_len <= {1'b0, ptr} + (PC_W+1)'(1);
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               if (Load_start) begin
                  state       <= LOAD;
                  ptr         <= '0;
                  Instr_valid <= 1'b0;
               end else if (!Stall) begin
                  if (Fetch_en) begin
                     Instr_valid <= 1'b1;
                     Pc_oob      <= fetch_oob;
`ifdef IMEM_PC_WRAP_EN
                     Opcode      <= rd_word[OPCODE_W-1:0];
                     Address     <= rd_word[WORD_W-1:OPCODE_W];
`else
                     if (fetch_oob) begin
                        Opcode  <= OPCODE_W'(NOP_OPCODE);
                        Address <= '0;
                     end else begin
                        Opcode  <= rd_word[OPCODE_W-1:0];
                        Address <= rd_word[WORD_W-1:OPCODE_W];
                     end
`endif
                  end else begin
                     Instr_valid <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Load_start;
   logic       Load_valid;
   logic       Load_last;
   logic [7:0] Load_data;
   logic       Load_busy;
   logic [5:0] Prog_len;
   logic       Fetch_en;
   logic       Stall;
   logic [4:0] Program_counter;
   logic [2:0] Opcode;
   logic [4:0] Address;
   logic       Instr_valid;
   logic       Pc_oob;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   instr_mem_loader dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Load_start      (Load_start),
      .Load_valid      (Load_valid),
      .Load_last       (Load_last),
      .Load_data       (Load_data),
      .Load_busy       (Load_busy),
      .Prog_len        (Prog_len),
      .Fetch_en        (Fetch_en),
      .Stall           (Stall),
      .Program_counter (Program_counter),
      .Opcode          (Opcode),
      .Address         (Address),
      .Instr_valid     (Instr_valid),
      .Pc_oob          (Pc_oob)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic load_word(input logic [7:0] d, input logic last);
      Load_valid = 1'b1;
      Load_data  = d;
      Load_last  = last;
      step();
      Load_valid = 1'b0;
      Load_last  = 1'b0;
   endtask

   task automatic fetch(input logic [4:0] pc);
      Fetch_en        = 1'b1;
      Program_counter = pc;
      step();
      Fetch_en        = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Load_start = 1'b0; Load_valid = 1'b0; Load_last = 1'b0;
      Load_data = '0; Fetch_en = 1'b0; Stall = 1'b0; Program_counter = '0;
      step();
      step();
      check("rst_opcode", 32'(Opcode), 0);
      check("rst_address", 32'(Address), 0);
      check("rst_valid", 32'(Instr_valid), 0);
      check("rst_oob", 32'(Pc_oob), 0);
      check("rst_prog_len", 32'(Prog_len), 0);
      check("rst_busy", 32'(Load_busy), 0);

      // Reset in the middle of a load
      Reset = 1'b0;
      Load_start = 1'b1; step(); Load_start = 1'b0;
      check("load_busy", 32'(Load_busy), 1);
      load_word(8'h11, 1'b0);
      load_word(8'h22, 1'b0);
      load_word(8'h33, 1'b0);
      Reset = 1'b1; step(); Reset = 1'b0;
      check("midrst_busy", 32'(Load_busy), 0);
      check("midrst_prog_len", 32'(Prog_len), 0);
      check("midrst_valid", 32'(Instr_valid), 0);

      fetch(5'd0);
      check("idle_fetch_valid", 32'(Instr_valid), 0);

      // Four-word program
      Load_start = 1'b1; step(); Load_start = 1'b0;
      load_word(8'h21, 1'b0);
      load_word(8'h4A, 1'b0);
      load_word(8'h93, 1'b0);
      load_word(8'hFF, 1'b1);
      check("p4_prog_len", 32'(Prog_len), 4);
      check("p4_busy", 32'(Load_busy), 0);

      fetch(5'd1);
      check("pc1_opcode", 32'(Opcode), 3'b010);
      check("pc1_address", 32'(Address), 5'b01001);
      check("pc1_valid", 32'(Instr_valid), 1);
      check("pc1_oob", 32'(Pc_oob), 0);

      fetch(5'd7);
`ifdef IMEM_PC_WRAP_EN
      check("pc7_opcode", 32'(Opcode), 7);
      check("pc7_address", 32'(Address), 31);
`else
      check("pc7_opcode", 32'(Opcode), 0);
      check("pc7_address", 32'(Address), 0);
`endif
      check("pc7_oob", 32'(Pc_oob), 1);
      check("pc7_valid", 32'(Instr_valid), 1);

      // Stall holds word 0 while PC moves
      Fetch_en = 1'b1; Program_counter = 5'd0; step();
      check("pc0_opcode", 32'(Opcode), 1);
      check("pc0_address", 32'(Address), 4);
      check("pc0_oob", 32'(Pc_oob), 0);
      Stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         Program_counter = 5'(i);
         step();
         check("stall_opcode", 32'(Opcode), 1);
         check("stall_address", 32'(Address), 4);
         check("stall_valid", 32'(Instr_valid), 1);
      end
      Stall = 1'b0; Fetch_en = 1'b0; step();
      check("release_valid", 32'(Instr_valid), 0);
      check("release_opcode_hold", 32'(Opcode), 1);

      // Reload from RUN with fetches requested, then overflow the array
      Fetch_en = 1'b1; Program_counter = 5'd1; Load_start = 1'b1; step(); Load_start = 1'b0;
      check("reload_busy", 32'(Load_busy), 1);
      check("reload_valid", 32'(Instr_valid), 0);
      check("reload_prog_len_hold", 32'(Prog_len), 4);
      for (int k = 1; k <= 40; k++) begin
         load_word(8'(k * 7), 1'b0);
         if (k == 16) check("stream_fetch_ignored", 32'(Instr_valid), 0);
         if (k == 31) check("stream_busy31", 32'(Load_busy), 1);
         if (k == 32) begin
            check("stream_busy32", 32'(Load_busy), 0);
            check("stream_prog_len", 32'(Prog_len), 32);
         end
      end
      Fetch_en = 1'b0;
      check("post_stream_prog_len", 32'(Prog_len), 32);

      // Word 32 = 224 = 0xE0 ; word 1 = 7
      fetch(5'd31);
      check("pc31_opcode", 32'(Opcode), 0);
      check("pc31_address", 32'(Address), 28);
      check("pc31_oob", 32'(Pc_oob), 0);
      fetch(5'd0);
      check("pc0b_opcode", 32'(Opcode), 7);
      check("pc0b_address", 32'(Address), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
